// File: rtl/fpaddsub_if.sv
// fpaddsub_if: start/operand request and result/flag bundle for fpaddsub.
interface fpaddsub_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
   localparam int W = 1 + EXP_W + MAN_W;
   logic start, op, done, busy, invalid, overflow;
   logic [W-1:0] a, b, sum;
   modport master (output start, op, a, b, input sum, done, busy, invalid, overflow);
   modport slave (input start, op, a, b, output sum, done, busy, invalid, overflow);
endinterface

// File: rtl/fpaddsub.sv
// fpaddsub: multi-cycle IEEE-style add/subtract, flush-to-zero, round-to-nearest-even.
module fpaddsub #(parameter int EXP_W = 8, parameter int MAN_W = 23) (
   input logic clk,
   input logic reset,
   fpaddsub_if.slave bus
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 4;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
   localparam logic signed [EXP_W+1:0] ONE = (EXP_W+2)'(1);
   typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK} state_t;
   state_t state_q;
   logic [W-1:0] a_q, b_q, sum_q;
   logic op_q, done_q, busy_q, inv_q, ovf_q, sign_q, sub_q;
   logic [MW-1:0] ma_q, mb_q;
   logic [MW:0] m_q;
   logic signed [EXP_W+1:0] e_q;
   logic [EXP_W-1:0] cnt_q, cnt_d;
   logic [EXP_W-1:0] ea, eb, el, es, diff;
   logic [MAN_W-1:0] fa, fb, fr;
   logic sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, special, nan_res;
   logic [W-1:0] spec_sum;
   logic [MAN_W:0] mant;
   logic [MAN_W+1:0] mr;
   logic inc, uf, of;
   logic signed [EXP_W+1:0] ef;
   assign ea = a_q[W-2 -: EXP_W];
   assign eb = b_q[W-2 -: EXP_W];
   assign fa = a_q[MAN_W-1:0];
   assign fb = b_q[MAN_W-1:0];
   assign sa = a_q[W-1];
   assign sb = b_q[W-1] ^ op_q;
   assign a_nan = &ea && |fa;
   assign b_nan = &eb && |fb;
   assign a_inf = &ea && ~|fa;
   assign b_inf = &eb && ~|fb;
   assign a_zero = ~|ea;
   assign b_zero = ~|eb;
   assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign nan_res = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
   assign spec_sum = nan_res ? QNAN :
                     (a_inf | b_inf) ? {a_inf ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                     (a_zero & b_zero) ? {sa & sb, {(W-1){1'b0}}} :
                     a_zero ? {sb, b_q[W-2:0]} : {sa, a_q[W-2:0]};
   // Larger magnitude becomes A so the subtraction below never goes negative
   assign swap = b_q[W-2:0] > a_q[W-2:0];
   assign el = swap ? eb : ea;
   assign es = swap ? ea : eb;
   assign diff = el - es;
   assign cnt_d = (MAN_W + 3 < 2**EXP_W && diff > EXP_W'(MAN_W + 3)) ? EXP_W'(MAN_W + 3) : diff;
   assign mant = m_q[MW-1:3];
   assign inc = m_q[2] & (m_q[1] | m_q[0] | mant[0]);
   assign mr = {1'b0, mant} + (MAN_W+2)'(inc);
   assign ef = e_q + (EXP_W+2)'(mr[MAN_W+1]);
   assign fr = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
   assign uf = ef[EXP_W+1] || ef == '0;
   assign of = ef >= EMAX;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         {a_q, b_q, sum_q, op_q, done_q, busy_q, inv_q, ovf_q, sign_q, sub_q} <= '0;
         {ma_q, mb_q, m_q, e_q, cnt_q} <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               a_q <= bus.a;
               b_q <= bus.b;
               op_q <= bus.op;
               inv_q <= 1'b0;
               ovf_q <= 1'b0;
               busy_q <= 1'b1;
               state_q <= UNPACK;
            end
            UNPACK: if (special) begin
               sum_q <= spec_sum;
               inv_q <= nan_res;
               done_q <= 1'b1;
               state_q <= PACK;
            end else begin
               sign_q <= swap ? sb : sa;
               sub_q <= sa ^ sb;
               e_q <= $signed({2'b00, el});
               ma_q <= {1'b1, swap ? fb : fa, 3'b000};
               mb_q <= {1'b1, swap ? fa : fb, 3'b000};
               cnt_q <= cnt_d;
               state_q <= cnt_d == '0 ? ADD : ALIGN;
            end
            ALIGN: begin
               mb_q <= {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
               cnt_q <= cnt_q - EXP_W'(1);
               if (cnt_q == EXP_W'(1)) state_q <= ADD;
            end
            ADD: begin
               m_q <= sub_q ? {1'b0, ma_q} - {1'b0, mb_q} : {1'b0, ma_q} + {1'b0, mb_q};
               state_q <= NORM;
            end
            NORM: if (m_q == '0) begin
               sum_q <= '0;
               done_q <= 1'b1;
               state_q <= PACK;
            end else if (m_q[MW]) begin
               m_q <= {1'b0, m_q[MW:2], m_q[1] | m_q[0]};
               e_q <= e_q + ONE;
            end else if (m_q[MW-1]) begin
               state_q <= ROUND;
            end else begin
               m_q <= m_q << 1;
               e_q <= e_q - ONE;
            end
            ROUND: begin
               sum_q <= uf ? {sign_q, {(W-1){1'b0}}} :
                        of ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign_q, ef[EXP_W-1:0], fr};
               ovf_q <= !uf && of;
               done_q <= 1'b1;
               state_q <= PACK;
            end
            PACK: begin
               busy_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.sum = sum_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
   assign bus.invalid = inv_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_fpaddsub.sv
// tb_fpaddsub: scoreboard bench for single- and half-precision fpaddsub builds.
module tb_fpaddsub;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   fpaddsub_if #(.EXP_W(8), .MAN_W(23)) bus();
   fpaddsub_if #(.EXP_W(5), .MAN_W(10)) hb();
   fpaddsub #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   fpaddsub #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .reset(reset), .bus(hb.slave));
   typedef struct packed {logic [31:0] sum; logic inv; logic ovf;} exp_t;
   typedef struct packed {logic [31:0] a; logic [31:0] b; logic op; logic [31:0] sum; logic inv; logic ovf;} vec_t;
   exp_t sq[$];
   exp_t hq[$];
   int total = 0, bad = 0, dones = 0;
   always @(negedge clk) begin
      if (bus.done) begin
         exp_t e;
         dones++;
         total++;
         if (sq.size() == 0) begin
            bad++;
            $display("FAIL sp_unexpected_done sum=%h", bus.sum);
         end else begin
            e = sq.pop_front();
            if ({bus.sum, bus.invalid, bus.overflow} !== {e.sum, e.inv, e.ovf}) begin
               bad++;
               $display("FAIL sp_result got sum=%h inv=%b ovf=%b want sum=%h inv=%b ovf=%b",
                        bus.sum, bus.invalid, bus.overflow, e.sum, e.inv, e.ovf);
            end
         end
      end
      if (hb.done) begin
         exp_t e;
         total++;
         if (hq.size() == 0) begin
            bad++;
            $display("FAIL hp_unexpected_done sum=%h", hb.sum);
         end else begin
            e = hq.pop_front();
            if ({hb.sum, hb.invalid, hb.overflow} !== {e.sum[15:0], e.inv, e.ovf}) begin
               bad++;
               $display("FAIL hp_result got sum=%h inv=%b ovf=%b want sum=%h inv=%b ovf=%b",
                        hb.sum, hb.invalid, hb.overflow, e.sum[15:0], e.inv, e.ovf);
            end
         end
      end
   end
   task automatic run(input vec_t v, output int cyc);
      int n = 0;
      while (bus.busy && n < 200) begin @(negedge clk); n++; end
      sq.push_back({v.sum, v.inv, v.ovf});
      bus.a = v.a; bus.b = v.b; bus.op = v.op; bus.start = 1'b1;
      cyc = 0;
      do begin @(negedge clk); bus.start = 1'b0; cyc++; end while (!bus.done && cyc < 100);
      total++;
      if (!bus.done) begin bad++; $display("FAIL sp_timeout got cycles=%0d want done", cyc); end
   endtask
   task automatic run_h(input logic [15:0] a, b, input logic op, input logic [15:0] s, input logic inv, ovf);
      int cyc = 0;
      while (hb.busy && cyc < 200) begin @(negedge clk); cyc++; end
      hq.push_back({16'h0, s, inv, ovf});
      hb.a = a; hb.b = b; hb.op = op; hb.start = 1'b1;
      cyc = 0;
      do begin @(negedge clk); hb.start = 1'b0; cyc++; end while (!hb.done && cyc < 100);
      total++;
      if (!hb.done) begin bad++; $display("FAIL hp_timeout got cycles=%0d want done", cyc); end
   endtask
   task automatic run_table(input vec_t t[]);
      int c;
      foreach (t[i]) run(t[i], c);
   endtask
   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      total++;
      if ({bus.sum, bus.done, bus.busy, bus.invalid, bus.overflow} !== 36'h0) begin
         bad++;
         $display("FAIL reset_state got sum=%h done=%b busy=%b inv=%b ovf=%b want all 0",
                  bus.sum, bus.done, bus.busy, bus.invalid, bus.overflow);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic test_basic();
      int c;
      run('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0}, c);
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse got done=%b want 0", bus.done); end
      repeat (4) @(negedge clk);
      total++;
      if (bus.sum !== 32'h40400000) begin bad++; $display("FAIL sum_hold got %h want 40400000", bus.sum); end
      run_table('{'{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0},
                  '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0},
                  '{32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 1'b0, 1'b0},
                  '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0},
                  '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0},
                  '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 1'b0, 1'b0}});
   endtask
   task automatic test_zero_special();
      run_table('{'{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0},
                  '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0},
                  '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0},
                  '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0},
                  '{32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1'b0, 1'b0},
                  '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0},
                  '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0},
                  '{32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 1'b1, 1'b0},
                  '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0},
                  '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0},
                  '{32'h01000000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0, 1'b0}});
   endtask
   task automatic test_rounding();
      run_table('{'{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
                  '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0},
                  '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 1'b0},
                  '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 1'b0, 1'b0}});
   endtask
   task automatic test_overflow();
      int c;
      run_table('{'{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1},
                  '{32'h7F7FFFFF, 32'hFF7FFFFF, 1'b1, 32'h7F800000, 1'b0, 1'b1},
                  '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 1'b0, 1'b1}});
      @(negedge clk);
      sq.push_back({32'h40000000, 1'b0, 1'b0});
      bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.op = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.invalid, bus.overflow} !== 2'b00) begin
         bad++;
         $display("FAIL flags_clear got inv=%b ovf=%b want 0 0", bus.invalid, bus.overflow);
      end
      c = 0;
      while (!bus.done && c < 100) begin @(negedge clk); c++; end
   endtask
   task automatic test_latency();
      int c;
      run('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0}, c);
      total++;
      if (c != 2) begin bad++; $display("FAIL special_latency got %0d want 2", c); end
      run('{32'h7F000000, 32'h3F800000, 1'b1, 32'h7F000000, 1'b0, 1'b0}, c);
      total++;
      if (c > 2 * 23 + 9) begin bad++; $display("FAIL max_latency got %0d want <= %0d", c, 2 * 23 + 9); end
   endtask
   task automatic test_back_to_back();
      int d0, c;
      @(negedge clk);
      d0 = dones;
      sq.push_back({32'h40400000, 1'b0, 1'b0});
      bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.a = 32'h7FC00000; bus.b = 32'h7F800000; bus.op = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      c = 0;
      while (!bus.done && c < 100) begin @(negedge clk); c++; end
      repeat (10) @(negedge clk);
      total++;
      if (dones - d0 != 1 || sq.size() != 0) begin
         bad++;
         $display("FAIL ignored_start got dones=%0d pending=%0d want 1 0", dones - d0, sq.size());
      end
   endtask
   task automatic test_reset_mid();
      int d0, c;
      @(negedge clk);
      bus.a = 32'h7F000000; bus.b = 32'h3F800000; bus.op = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      d0 = dones;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({bus.sum, bus.done, bus.busy, bus.invalid, bus.overflow} !== 36'h0) begin
         bad++;
         $display("FAIL reset_mid got sum=%h done=%b busy=%b inv=%b ovf=%b want all 0",
                  bus.sum, bus.done, bus.busy, bus.invalid, bus.overflow);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      total++;
      if (dones != d0) begin bad++; $display("FAIL abandoned_done got %0d want 0", dones - d0); end
      run('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0}, c);
   endtask
   task automatic test_half();
      run_h(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0);
      run_h(16'h4000, 16'h3C00, 1'b0, 16'h4200, 1'b0, 1'b0);
      run_h(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0);
      run_h(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b0, 1'b1);
      run_h(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b1, 1'b0);
   endtask
   initial begin
      {bus.start, bus.op, bus.a, bus.b} = '0;
      {hb.start, hb.op, hb.a, hb.b} = '0;
      test_reset();
      test_basic();
      test_zero_special();
      test_rounding();
      test_overflow();
      test_latency();
      test_back_to_back();
      test_reset_mid();
      test_half();
      repeat (5) @(negedge clk);
      total++;
      if (sq.size() != 0 || hq.size() != 0) begin
         bad++;
         $display("FAIL pending_results got sp=%0d hp=%0d want 0 0", sq.size(), hq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fpaddsub.md
FPADDSUB -- requirements
Module: fpaddsub

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 Parameter MAN_W, default 23, stored fraction width (>=4); W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 op  input  1  0 = a+b, 1 = a-b.
REQ-007 a, b  input  W each  IEEE-style operands {sign, exponent, fraction}, captured on accepted start.
REQ-008 sum  output  W  result; held stable from done until next accepted start.
REQ-009 done  output  1  one-cycle pulse marking sum valid.
REQ-010 busy  output  1  high from cycle after accepted start through done cycle.
REQ-011 invalid  output  1  result is NaN from NaN input or inf-inf; valid with done.
REQ-012 overflow  output  1  finite operands rounded to infinity; valid with done.

Function
REQ-013 Start accepted when start=1 and busy=0; start while busy=1 shall be ignored, with no effect on the operation in flight.
REQ-014 States: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK; PACK asserts done, then returns to IDLE.
REQ-015 UNPACK: effective sign of b = b.sign XOR op; exponent 0 treated as zero (subnormal inputs flushed to signed zero); hidden 1 prepended otherwise.
REQ-016 UNPACK special cases go directly to PACK: any NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=1; inf-inf of opposite effective sign -> canonical qNaN, invalid=1; one inf -> that inf with its effective sign; one zero -> other operand unchanged (effective sign applied); both zero -> +0 unless both effective signs negative, then -0.
REQ-017 Operand swap so the larger-magnitude operand is A; result sign = sign of A.
REQ-018 ALIGN: shift smaller significand right one bit per cycle, carrying guard, round and sticky bits (sticky = OR of all bits shifted out); at most MAN_W+3 shift cycles; larger exponent difference collapses the operand to sticky only after the cap.
REQ-019 ADD: one cycle; magnitude add if effective signs match, else subtract (A-B, non-negative); width MAN_W+4 plus carry bit.
REQ-020 NORM: carry-out -> right shift 1 (sticky accumulates), exponent+1, one cycle; otherwise left shift one bit per cycle until hidden bit set, exponent-1 per shift; zero magnitude -> +0, skip to PACK.
REQ-021 ROUND: round-to-nearest-even using guard/round/sticky; mantissa carry-out renormalises and increments exponent in the same cycle.
REQ-022 Exponent reaching all ones after ROUND -> signed infinity, overflow=1; exponent underflowing to <=0 -> signed zero (flush, no flag).
REQ-023 Worst-case latency, start to done, shall not exceed 2*MAN_W+10 cycles; special cases complete in 3 cycles.
REQ-024 invalid and overflow shall be cleared on every accepted start.

Reset
REQ-025 reset=1 shall immediately force state IDLE, sum=0, done=0, busy=0, invalid=0, overflow=0, regardless of clock.
REQ-026 Reset asserted mid-operation shall abandon it with no done pulse; first start after release shall behave as from power-up.

Verification
REQ-027 a=0x3F800000, b=0x40000000, op=0 -> sum=0x40400000, done one cycle, flags 0.
REQ-028 a=0x3F800000, b=0x3F800000, op=1 -> sum=0x00000000 (+0); a=0x80000000, b=0x00000000, op=1 -> 0x80000000.
REQ-029 a=0x7F800000, b=0x7F800000, op=1 -> sum=0x7FC00000, invalid=1; a=0x7FC00001, any b -> 0x7FC00000, invalid=1.
REQ-030 a=b=0x7F7FFFFF, op=0 -> sum=0x7F800000, overflow=1.
REQ-031 Rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie to even); 0x3F800000+0x33C00000 -> 0x3F800001; 0x3F800000+0x00000001 -> 0x3F800000 (subnormal flushed).
REQ-032 Reset pulse mid-ALIGN -> outputs zero, no done; start re-pulsed during busy ignored; EXP_W=5/MAN_W=10 build: 0x3C00+0x3C00 -> 0x4000.
